// File: rtl/instr_buffer.sv
// Dual-lane instruction FIFO between decode and dispatch.
// Accepts up to two instructions per cycle, presents the two oldest entries,
// and retires in order using dispatch's per-lane accept mask.
// Optional feature: define IB_PERF_CNT_EN to add the empty_cycles_o counter.

package instr_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } instr_info_t;

    typedef struct packed {
        instr_info_t instr_info;
        logic [4:0]  rd;
        logic [3:0]  fu_sel;
    } id_dispatch_struct;

endpackage

module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LANES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          stall,
    input  logic [1:0]                    push_valid_i,
    input  id_dispatch_struct [1:0]       push_data_i,
    output logic                          push_ready_o,
    output logic [1:0]                    out_valid_o,
    output id_dispatch_struct [1:0]       out_data_o,
    input  logic [1:0]                    accept_i,
`ifdef IB_PERF_CNT_EN
    output logic [31:0]                   empty_cycles_o,
`endif
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned CntW = $clog2(LANES) + 1;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [PtrW-1:0]   count;
    logic [IdxW-1:0]   head_idx, head1_idx;
    logic [IdxW-1:0]   tail_idx, tail1_idx;
    logic [CntW-1:0]   push_cnt, pop_cnt;
    logic [1:0]        eff_accept;

    id_dispatch_struct mem_q [DEPTH];
    id_dispatch_struct mem_d [DEPTH];

    assign count     = tail_q - head_q;
    assign head_idx  = head_q[IdxW-1:0];
    assign head1_idx = head_idx + IdxW'(1);
    assign tail_idx  = tail_q[IdxW-1:0];
    assign tail1_idx = tail_idx + IdxW'(1);
    assign count_o   = count;

    // Head presentation; invalid lanes are forced to zero.
    always_comb begin
        out_valid_o[0] = (count != '0);
        out_valid_o[1] = (count >= PtrW'(2));
        out_data_o[0]  = out_valid_o[0] ? mem_q[head_idx]  : '0;
        out_data_o[1]  = out_valid_o[1] ? mem_q[head1_idx] : '0;
        // Space for a full pair is required; same-cycle pops are not credited.
        push_ready_o   = (count <= PtrW'(DEPTH - 2));
    end

    // Write and pointer next-state, flush overriding push and pop.
    always_comb begin
        mem_d    = mem_q;
        push_cnt = '0;
        pop_cnt  = '0;
        head_d   = head_q;
        tail_d   = tail_q;

        eff_accept = accept_i & out_valid_o;

        if (push_ready_o && !flush) begin
            case (push_valid_i)
                2'b01: begin
                    mem_d[tail_idx] = push_data_i[0];
                    push_cnt        = CntW'(1);
                end
                2'b10: begin
                    // Lone lane-1 instruction is packed into the tail slot.
                    mem_d[tail_idx] = push_data_i[1];
                    push_cnt        = CntW'(1);
                end
                2'b11: begin
                    mem_d[tail_idx]  = push_data_i[0];
                    mem_d[tail1_idx] = push_data_i[1];
                    push_cnt         = CntW'(2);
                end
                default: push_cnt = '0;
            endcase
        end

        // In-order retirement: lane 1 alone never retires.
        if (!stall && !flush) begin
            if (eff_accept[0]) begin
                pop_cnt = eff_accept[1] ? CntW'(2) : CntW'(1);
            end
        end

        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PtrW'(pop_cnt);
            tail_d = tail_q + PtrW'(push_cnt);
        end
    end

    // Pointer state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; contents need no reset since output is gated by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef IB_PERF_CNT_EN
    logic [31:0] empty_cycles_q, empty_cycles_d;

    // Saturating count of empty, non-flush cycles.
    always_comb begin
        empty_cycles_d = empty_cycles_q;
        if ((count == '0) && !flush && (empty_cycles_q != 32'hFFFF_FFFF)) begin
            empty_cycles_d = empty_cycles_q + 32'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_cycles_q <= '0;
        end else begin
            empty_cycles_q <= empty_cycles_d;
        end
    end

    assign empty_cycles_o = empty_cycles_q;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer using a queue-based scoreboard.
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic                    stall;
    logic [1:0]              push_valid_i;
    id_dispatch_struct [1:0] push_data_i;
    logic                    push_ready_o;
    logic [1:0]              out_valid_o;
    id_dispatch_struct [1:0] out_data_o;
    logic [1:0]              accept_i;
    logic [$clog2(DEPTH):0]  count_o;
`ifdef IB_PERF_CNT_EN
    logic [31:0]             empty_cycles_o;
`endif

    instr_buffer #(
        .DEPTH (DEPTH),
        .LANES (2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .stall         (stall),
        .push_valid_i  (push_valid_i),
        .push_data_i   (push_data_i),
        .push_ready_o  (push_ready_o),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .accept_i      (accept_i),
`ifdef IB_PERF_CNT_EN
        .empty_cycles_o(empty_cycles_o),
`endif
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_dispatch_struct exp_q[$];
    int total = 0;
    int bad   = 0;
    int seq_n = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic id_dispatch_struct mk_instr();
        id_dispatch_struct s;
        seq_n++;
        s.instr_info.valid = 1'b1;
        s.instr_info.pc    = 32'(seq_n) << 2;
        s.instr_info.instr = $urandom;
        s.rd               = 5'(seq_n);
        s.fu_sel           = 4'($urandom_range(0, 15));
        return s;
    endfunction

    // Compare all outputs against the scoreboard state.
    task automatic check_outputs();
        int unsigned n;
        id_dispatch_struct e0, e1;
        n  = exp_q.size();
        e0 = (n >= 1) ? exp_q[0] : '0;
        e1 = (n >= 2) ? exp_q[1] : '0;
        check_eq("count",      128'(count_o),        128'(n));
        check_eq("out_valid",  128'(out_valid_o),    128'({n >= 2, n >= 1}));
        check_eq("push_ready", 128'(push_ready_o),   128'((DEPTH - n) >= 2));
        check_eq("data0",      128'(out_data_o[0]),  128'(e0));
        check_eq("data1",      128'(out_data_o[1]),  128'(e1));
    endtask

    // One cycle: check, drive, update model, advance to next negedge.
    task automatic step(input logic [1:0] pv, input id_dispatch_struct d0,
                        input id_dispatch_struct d1, input logic [1:0] acc,
                        input logic st, input logic fl);
        int unsigned n;
        logic ready;
        logic [1:0] eff;
        check_outputs();
        push_valid_i   = pv;
        push_data_i[0] = d0;
        push_data_i[1] = d1;
        accept_i       = acc;
        stall          = st;
        flush          = fl;
        n     = exp_q.size();
        ready = ((DEPTH - n) >= 2);
        eff   = acc & {n >= 2, n >= 1};
        if (fl) begin
            exp_q.delete();
        end else begin
            if (!st && eff[0]) begin
                void'(exp_q.pop_front());
                if (eff[1]) void'(exp_q.pop_front());
            end
            if (ready) begin
                if (pv == 2'b01) exp_q.push_back(d0);
                if (pv == 2'b10) exp_q.push_back(d1);
                if (pv == 2'b11) begin
                    exp_q.push_back(d0);
                    exp_q.push_back(d1);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            step(2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
        end
        check_outputs();
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        stall        = 1'b0;
        push_valid_i = '0;
        push_data_i  = '0;
        accept_i     = '0;

        // Reset state.
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle then pair push A,B; pop both.
        idle();
        idle();
        idle();
        step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
`ifdef IB_PERF_CNT_EN
        check_eq("empty_cycles_after_push", 128'(empty_cycles_o), 128'(4));
`endif
        step(2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
`ifdef IB_PERF_CNT_EN
        check_eq("empty_cycles_hold", 128'(empty_cycles_o), 128'(4));
`endif
        check_outputs();

        // Partial issue: A,B,C then accept 01, then 10.
        step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        step(2'b01, mk_instr(), '0, 2'b00, 1'b0, 1'b0);
        step(2'b00, '0, '0, 2'b01, 1'b0, 1'b0);
        step(2'b00, '0, '0, 2'b10, 1'b0, 1'b0);
        idle();
        drain();

        // Stall holds pops for three cycles.
        step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b00, '0, '0, 2'b11, 1'b1, 1'b0);
        step(2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
        check_outputs();

        // Fill, dropped push when full, then pop/push across the wrap.
        for (int i = 0; i < 4; i++) step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        step(2'b10, '0, mk_instr(), 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(2'b11, mk_instr(), mk_instr(), 2'b11, 1'b0, 1'b0);
        drain();

        // Count DEPTH-1 refuses even a single push.
        for (int i = 0; i < 3; i++) step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        step(2'b01, mk_instr(), '0, 2'b00, 1'b0, 1'b0);
        step(2'b01, mk_instr(), '0, 2'b00, 1'b0, 1'b0);
        drain();

        // Flush at count 5 with concurrent push and accept.
        step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        step(2'b01, mk_instr(), '0, 2'b00, 1'b0, 1'b0);
        step(2'b11, mk_instr(), mk_instr(), 2'b11, 1'b1, 1'b1);
        idle();

        // Asynchronous reset mid-operation.
        step(2'b11, mk_instr(), mk_instr(), 2'b00, 1'b0, 1'b0);
        step(2'b11, mk_instr(), mk_instr(), 2'b01, 1'b0, 1'b0);
        push_valid_i = '0;
        accept_i     = '0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom_range(0, 3)), mk_instr(), mk_instr(), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
